gpu_pixel_writer: RTL

//  Framebuffer write stage directly downstream of the rectangle-fill rasteriser.

---
 rtl/gpu_pixel_writer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/gpu_pixel_writer.sv
// gpu_pixel_writer: buffers rasteriser pixels in a FIFO and issues single-beat framebuffer writes.
// Ports:
//   clk, n_rst                  clock, asynchronous active-low reset
//   i_x, i_y                    pixel column/row; address = i_y*SCREEN_W + i_x (truncated to ADDR_BITS)
//   i_r, i_g, i_b               pixel colour channels
//   i_valid, o_ready            pixel handshake; o_ready = FIFO not full
//   o_mem_addr, o_mem_wdata     write address and {r,g,b} to the SRAM controller
//   o_mem_we, i_mem_ack         write request held stable until acknowledged
//   i_clr                       synchronous clear of the statistics counters
//   o_pix_count                 saturating count of completed writes
//   o_busy                      FIFO non-empty or write outstanding
//   o_clip_count                saturating count of out-of-range pixels (GPU_PIXEL_WRITER_CLIP_EN only)
// Build option: define GPU_PIXEL_WRITER_CLIP_EN to discard off-screen pixels instead of writing them.
module gpu_pixel_writer #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int ADDR_BITS  = 19,
    parameter int CH_BITS    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int X_BITS     = $clog2(SCREEN_W),
    parameter int Y_BITS     = $clog2(SCREEN_H)
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [X_BITS-1:0]      i_x,
    input  logic [Y_BITS-1:0]      i_y,
    input  logic [CH_BITS-1:0]     i_r,
    input  logic [CH_BITS-1:0]     i_g,
    input  logic [CH_BITS-1:0]     i_b,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [ADDR_BITS-1:0]   o_mem_addr,
    output logic [3*CH_BITS-1:0]   o_mem_wdata,
    output logic                   o_mem_we,
    input  logic                   i_mem_ack,
    input  logic                   i_clr,
    output logic [ADDR_BITS:0]     o_pix_count,
    output logic                   o_busy
`ifdef GPU_PIXEL_WRITER_CLIP_EN
    ,output logic [15:0]           o_clip_count
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = ADDR_BITS + 3 * CH_BITS;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t               r_state, w_state_nxt;
    logic [DW-1:0]        r_fifo [FIFO_DEPTH];
    logic [PW-1:0]        r_wptr, r_rptr;
    logic [CW-1:0]        r_count, w_count_nxt;
    logic [ADDR_BITS-1:0] r_mem_addr, w_addr;
    logic [3*CH_BITS-1:0] r_mem_wdata;
    logic [ADDR_BITS:0]   r_pix_count;
    logic                 r_busy, w_keep, w_push, w_pop, w_full, w_empty, w_adv;

    assign w_full      = r_count == CW'(FIFO_DEPTH);
    assign w_empty     = r_count == '0;
    assign o_ready     = !w_full;
    assign w_addr      = ADDR_BITS'(32'(i_y) * SCREEN_W + 32'(i_x));
`ifdef GPU_PIXEL_WRITER_CLIP_EN
    assign w_keep      = (32'(i_x) < SCREEN_W) && (32'(i_y) < SCREEN_H);
`else
    assign w_keep      = 1'b1;
`endif
    assign w_push      = i_valid && o_ready && w_keep;
    assign o_mem_we    = r_state == WRITE;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_pix_count = r_pix_count;
    assign o_busy      = r_busy;

    // The write slot frees up when idle or when the current write is acked; it refills
    // only from entries already in the FIFO, so a same-cycle push into an empty FIFO waits.
    always_comb begin
        w_adv       = (r_state == IDLE) || i_mem_ack;
        w_pop       = w_adv && !w_empty;
        w_state_nxt = w_adv ? (w_empty ? IDLE : WRITE) : r_state;
        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_busy      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_busy  <= (w_count_nxt != '0) || (w_state_nxt == WRITE);
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop) begin
                r_rptr                     <= r_rptr + PW'(1);
                {r_mem_addr, r_mem_wdata}  <= r_fifo[r_rptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= {w_addr, i_r, i_g, i_b};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_pix_count <= '0;
        else if (i_clr) r_pix_count <= '0;
        else if (o_mem_we && i_mem_ack && !(&r_pix_count)) r_pix_count <= r_pix_count + (ADDR_BITS+1)'(1);
    end

`ifdef GPU_PIXEL_WRITER_CLIP_EN
    logic [15:0] r_clip_count;

    assign o_clip_count = r_clip_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_clip_count <= '0;
        else if (i_clr) r_clip_count <= '0;
        else if (i_valid && o_ready && !w_keep && !(&r_clip_count)) r_clip_count <= r_clip_count + 16'd1;
    end
`endif
endmodule
